// File: rtl/mem_pkg.sv
// Shared memory-side types: cache<->memory block interfaces and the
// arbiter state encoding used when two caches share one memory port.
package mem_pkg;

  localparam int BLOCKSIZE = 128;
  localparam int ARB_PORTS = 2;

  typedef struct packed {
    logic                 Valid;
    logic                 Wen;
    logic [31:0]          Addr;
    logic [BLOCKSIZE-1:0] WriteD;
  } CacheToMem_t;

  typedef struct packed {
    logic                 Ready;
    logic [BLOCKSIZE-1:0] ReadD;
  } MemToCache_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: bit 0 is the I-cache, bit 1 the
// D-cache; on a tie the port that was not served last wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req_i,
  input  logic                 last_i,
  output logic                 gnt_i_o,
  output logic                 gnt_d_o
);

  // last_i = 1 means the D-cache was served most recently.
  assign gnt_i_o = req_i[0] & (~req_i[1] | last_i);
  assign gnt_d_o = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the L1 I-cache and D-cache,
// granting one whole block transaction at a time, with completion counters.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  CacheToMem_t ICacheD_i,
  input  CacheToMem_t DCacheD_i,
  input  MemToCache_t MemD_i,
  output MemToCache_t ICacheD_o,
  output MemToCache_t DCacheD_o,
  output CacheToMem_t MemD_o,
  output logic [CNT_W-1:0] ICnt_o,
  output logic [CNT_W-1:0] DCnt_o
);

  arb_state_t       state_q;
  logic             last_d;
  logic [CNT_W-1:0] icnt_q;
  logic [CNT_W-1:0] dcnt_q;
  logic             gnt_i;
  logic             gnt_d;

  rr_arb2 u_rr_arb2 (
    .req_i   ({DCacheD_i.Valid, ICacheD_i.Valid}),
    .last_i  (last_d),
    .gnt_i_o (gnt_i),
    .gnt_d_o (gnt_d)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      last_d  <= 1'b1;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt_i)      state_q <= ARB_GRANT_I;
          else if (gnt_d) state_q <= ARB_GRANT_D;
        end
        ARB_GRANT_I: begin
          if (MemD_i.Ready) begin
            state_q <= ARB_IDLE;
            last_d  <= 1'b0;
            icnt_q  <= icnt_q + CNT_W'(1);
          end
        end
        ARB_GRANT_D: begin
          if (MemD_i.Ready) begin
            state_q <= ARB_IDLE;
            last_d  <= 1'b1;
            dcnt_q  <= dcnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a zero default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    MemD_o    = '0;
    ICacheD_o = '0;
    DCacheD_o = '0;
    case (state_q)
      ARB_GRANT_I: begin
        MemD_o    = ICacheD_i;
        ICacheD_o = MemD_i;
      end
      ARB_GRANT_D: begin
        MemD_o    = DCacheD_i;
        DCacheD_o = MemD_i;
      end
      default: ;
    endcase
  end

  assign ICnt_o = icnt_q;
  assign DCnt_o = dcnt_q;

endmodule
